// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel UART receiver.
//
// Synchronizes UART_rx with two flops, confirms the start bit at mid-bit, then samples the
// eight data bits LSB first at bit centres and checks the stop bit. A good frame updates
// RX_data and pulses RX_status for one cycle. A stop bit sampled low pulses RX_err instead,
// and the receiver waits for the line to return high before looking for another start bit.
//
// Parameters:
//   CLK_DIV    sys_clk cycles per bit (4..65535); the half-bit point is CLK_DIV/2.
// Ports:
//   sys_clk    system clock, rising edge
//   reset      asynchronous active-low reset
//   UART_rx    serial input, idle high, asynchronous to sys_clk
//   RX_data    last correctly received byte, held until the next good byte
//   RX_status  one-cycle pulse when RX_data has just been updated
//   RX_err     one-cycle pulse on a framing error
//   RX_busy    high whenever the receiver is not idle
module uart_receiver #(
  parameter int unsigned CLK_DIV = 5208
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       UART_rx,
  output logic [7:0] RX_data,
  output logic       RX_status,
  output logic       RX_err,
  output logic       RX_busy
);

  // Registered cnt equals these on the sample edge (cnt is 0 the cycle after a reload).
  localparam logic [15:0] HalfLast = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] BitLast  = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [1:0]  sync_q;
  logic        rxs;

  // Both flops reset high so an idle line never looks like a start bit after reset.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], UART_rx};
    end
  end

  assign rxs = sync_q[1];

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      RX_data   <= 8'h00;
      RX_status <= 1'b0;
      RX_err    <= 1'b0;
      RX_busy   <= 1'b0;
    end else begin
      // Strobes are only ever high for the single cycle after they are set.
      RX_status <= 1'b0;
      RX_err    <= 1'b0;

      case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_q <= StStart;
            cnt_q   <= 16'd0;
            RX_busy <= 1'b1;
          end
        end

        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= 16'd0;
            if (!rxs) begin
              state_q <= StData;
              idx_q   <= 3'd0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch, silently.
              state_q <= StIdle;
              RX_busy <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q          <= 16'd0;
            shift_q[idx_q] <= rxs;
            if (idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= 16'd0;
            if (rxs) begin
              // Back to idle at stop mid-bit so a back-to-back start edge is not missed.
              RX_data   <= shift_q;
              RX_status <= 1'b1;
              state_q   <= StIdle;
              RX_busy   <= 1'b0;
            end else begin
              RX_err  <= 1'b1;
              state_q <= StWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StWaitHigh: begin
          // A held-low (break) line stays here, so it reports one error and no frames.
          if (rxs) begin
            state_q <= StIdle;
            RX_busy <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          cnt_q   <= 16'd0;
          RX_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver.
//
// A fast instance (CLK_DIV=16) takes a table of directed frames, a glitch, a mid-frame reset
// and a run of random frames. Expected pulse times come from frame arithmetic: the line
// falls at cycle C, so the strobe is seen at C + 3 + HALF + 9*CLK_DIV. A second instance at
// the default rate receives a single byte.
module tb_uart_receiver;

  localparam int unsigned Div     = 16;
  localparam int unsigned Half    = Div / 2;
  localparam int unsigned SlowDiv = 5208;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       uart_rx_slow;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_err;
  logic       rx_busy;
  logic [7:0] rx_data_slow;
  logic       rx_status_slow;
  logic       rx_err_slow;
  logic       rx_busy_slow;

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  uart_receiver #(
    .CLK_DIV(Div)
  ) u_dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .UART_rx  (uart_rx),
    .RX_data  (rx_data),
    .RX_status(rx_status),
    .RX_err   (rx_err),
    .RX_busy  (rx_busy)
  );

  uart_receiver u_dut_slow (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .UART_rx  (uart_rx_slow),
    .RX_data  (rx_data_slow),
    .RX_status(rx_status_slow),
    .RX_err   (rx_err_slow),
    .RX_busy  (rx_busy_slow)
  );

  typedef struct {
    int         cyc;
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    int         gap;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  int         n_checks = 0;
  int         n_errors = 0;
  int         busy_cnt = 0;
  int         slow_cnt = 0;
  int         slow_cyc = 0;
  logic [7:0] slow_data = 8'h00;
  logic       prev_status = 1'b0;
  logic       prev_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge sys_clk) begin
    if (rx_status === 1'b1 || rx_err === 1'b1) begin
      chk("status_err_exclusive", {31'd0, rx_status & rx_err}, 32'd0);
      got_q.push_back('{cyc, rx_err, rx_data});
    end
    if (prev_status) chk("status_width", {31'd0, rx_status}, 32'd0);
    if (prev_err) chk("err_width", {31'd0, rx_err}, 32'd0);
    prev_status = rx_status;
    prev_err    = rx_err;
    if (rx_busy === 1'b1) busy_cnt++;
    if (rx_status_slow === 1'b1) begin
      slow_cnt++;
      slow_cyc  = cyc;
      slow_data = rx_data_slow;
    end
  end

  // Drive the fast line to v for n cycles; entered and left 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    uart_rx = v;
    if (n > 0) begin
      repeat (n) @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_low,
                            output int c);
    c = cyc;
    hold(1'b0, Div);
    for (int k = 0; k < 8; k++) hold(b[k], Div);
    hold(stop, Div);
    if (hold_low > 0) hold(1'b0, hold_low);
  endtask

  task automatic compare_events(input string tag);
    ev_t e;
    ev_t g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_missing: got no event, expected one at cycle %0d", tag, e.cyc);
      end else begin
        g = got_q.pop_front();
        chk({tag, "_cyc"}, g.cyc, e.cyc);
        chk({tag, "_kind"}, {31'd0, g.is_err}, {31'd0, e.is_err});
        chk({tag, "_data"}, {24'd0, g.data}, {24'd0, e.data});
      end
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL %s_extra: got event at cycle %0d, expected none", tag, g.cyc);
    end
  endtask

  vec_t       vecs[6];
  int         c;
  int         gap;
  logic [7:0] b;
  logic       stop;
  logic [7:0] model_data;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0,  20, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 48, 20, 1'b1, 8'hA5};  // break: held low 3 more bit times
    vecs[2] = '{8'h55, 1'b1, 0,  20, 1'b0, 8'h55};
    vecs[3] = '{8'h00, 1'b1, 0,  0,  1'b0, 8'h00};  // continuous stream, single stop bits
    vecs[4] = '{8'hFF, 1'b1, 0,  0,  1'b0, 8'hFF};
    vecs[5] = '{8'h81, 1'b1, 0,  20, 1'b0, 8'h81};

    // Reset state.
    reset        = 1'b0;
    uart_rx      = 1'b1;
    uart_rx_slow = 1'b1;
    @(posedge sys_clk);
    #1;
    hold(1'b1, 3);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    chk("reset_status", {31'd0, rx_status}, 32'd0);
    chk("reset_err", {31'd0, rx_err}, 32'd0);
    chk("reset_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b1;
    hold(1'b1, 5);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].hold_low, c);
      exp_q.push_back('{c + 3 + Half + 9 * Div, vecs[i].exp_err, vecs[i].exp_data});
      compare_events($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_hold", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
      hold(1'b1, vecs[i].gap);
    end

    // 4-cycle low glitch: busy for exactly HALF cycles, nothing reported.
    busy_cnt = 0;
    hold(1'b0, 4);
    hold(1'b1, 30);
    chk("glitch_busy_cycles", busy_cnt, Half);
    chk("glitch_no_event", got_q.size(), 32'd0);
    chk("glitch_data_kept", {24'd0, rx_data}, 32'h81);

    // Reset in the middle of data bit 4.
    b = 8'hC3;
    hold(1'b0, Div);
    for (int k = 0; k < 4; k++) hold(b[k], Div);
    hold(b[4], Half);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_data", {24'd0, rx_data}, 32'd0);
    chk("midreset_status", {31'd0, rx_status}, 32'd0);
    chk("midreset_err", {31'd0, rx_err}, 32'd0);
    chk("midreset_busy", {31'd0, rx_busy}, 32'd0);
    uart_rx = 1'b1;
    @(posedge sys_clk);
    #1;
    hold(1'b1, 3);
    reset = 1'b1;
    hold(1'b1, 20);
    chk("midreset_no_event", got_q.size(), 32'd0);
    send_frame(8'h7E, 1'b1, 0, c);
    exp_q.push_back('{c + 3 + Half + 9 * Div, 1'b0, 8'h7E});
    compare_events("after_reset");
    hold(1'b1, 10);

    // Random frames against the frame-level model.
    model_data = 8'h7E;
    for (int i = 0; i < 16; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      send_frame(b, stop, 0, c);
      exp_q.push_back('{c + 3 + Half + 9 * Div, !stop, stop ? b : model_data});
      if (stop) model_data = b;
      compare_events("rand");
      hold(1'b1, gap);
    end
    hold(1'b1, 10);
    chk("rand_final_data", {24'd0, rx_data}, {24'd0, model_data});

    // Default rate, one byte on the slow instance.
    chk("slow_idle_no_event", slow_cnt, 32'd0);
    b = 8'h5A;
    c = cyc;
    uart_rx_slow = 1'b0;
    repeat (SlowDiv) @(posedge sys_clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      uart_rx_slow = b[k];
      repeat (SlowDiv) @(posedge sys_clk);
      #1;
    end
    uart_rx_slow = 1'b1;
    repeat (SlowDiv + 20) @(posedge sys_clk);
    #1;
    chk("slow_count", slow_cnt, 32'd1);
    chk("slow_cyc", slow_cyc, c + 3 + SlowDiv / 2 + 9 * SlowDiv);
    chk("slow_data", {24'd0, slow_data}, 32'h5A);
    chk("slow_err", {31'd0, rx_err_slow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for 8N1 frames, the receive-side counterpart of the team's UART transmitter; default rate 9600 baud from a 50 MHz `sys_clk`. It synchronizes the asynchronous `UART_rx` line and validates the start bit at mid-bit. Data bits are sampled LSB first at bit centres and the stop bit is checked. Each good byte is presented on `RX_data` with a one-cycle `RX_status` strobe; a bad stop bit produces an `RX_err` strobe instead.

## Interface
- `CLK_DIV`, 5208: `sys_clk` cycles per bit; legal range 4..65535. `HALF` = `CLK_DIV/2` (integer division), derived, not a parameter.
- `sys_clk`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-low; clock sys_clk.
- `UART_rx`  in  1  serial line, idle high, asynchronous to `sys_clk`.
- `RX_data`  out  8  last correctly received byte; holds until the next good byte.
- `RX_status`  out  1  one-cycle pulse: `RX_data` has just been updated.
- `RX_err`  out  1  one-cycle pulse: framing error (stop bit sampled 0).
- `RX_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Input path: 2-flop synchronizer on `UART_rx`, both flops reset to 1. All decisions use the synchronizer output `rxs`.
- Counter `cnt` is 16 bits. On every state transition that starts a timed interval, `cnt` loads 0. Otherwise it increments each cycle. A "sample edge" is the edge on which the registered `cnt` equals the limit.
- Bit index is 3 bits; the shift register is 8 bits.
- IDLE: if `rxs`==0 -> START, `cnt`<=0. The cycle this happens is t0.
- START: sample at `cnt`==`HALF`-1.
  - `rxs`==0 -> DATA, `cnt`<=0, index<=0.
  - `rxs`==1 -> IDLE (glitch rejected; no flag raised).
- DATA: at `cnt`==`CLK_DIV`-1, shift[index]<=`rxs`, `cnt`<=0.
  - If index==7 -> STOP.
  - Else index<=index+1.
- STOP: sample at `cnt`==`CLK_DIV`-1.
  - `rxs`==1 -> `RX_data`<=shift, `RX_status`<=1, -> IDLE.
  - `rxs`==0 -> `RX_err`<=1, `RX_data` unchanged, -> WAIT_HIGH.
- WAIT_HIGH: remain until `rxs`==1, then -> IDLE. A held-low line (break) yields exactly one `RX_err` and no spurious frames.
- `RX_status` and `RX_err` are registered. Each is forced to 0 on every cycle in which it is not being set, and they are never high together.
- Reset (any time, including mid-frame) asynchronously clears all of the following:
  - state -> IDLE; `cnt`, index, shift -> 0.
  - `RX_data`=0x00, `RX_status`=0, `RX_err`=0, `RX_busy`=0.
  - synchronizer flops -> 1.
- The partial frame is discarded. After reset is released, a line that is still low is treated as a start bit.

## Timing
- t0 is 2 cycles after the `UART_rx` falling edge (synchronizer latency).
- Sample edges:
  - start check at t0+`HALF`;
  - data bit k (k=0..7) at t0+`HALF`+(k+1)·`CLK_DIV`;
  - stop bit at t0+`HALF`+9·`CLK_DIV`.
- `RX_status`/`RX_err` go high in the cycle after the stop sample edge, for exactly 1 cycle. `RX_data` changes on that same edge.
- Default total latency, pin falling edge to `RX_status` high: 2+2604+46872 = 49478 cycles, plus 1 edge for registering.
- `RX_busy` rises in the cycle after t0 and falls in the cycle after the START-reject / stop-OK edge, or after WAIT_HIGH exits.
- Back-to-back frames: the FSM re-enters IDLE at stop mid-bit. A start edge arriving ≥1 cycle later is accepted, so a 1-stop-bit continuous stream is received without loss.
- Tolerated baud mismatch: ±4% relative to `CLK_DIV`.

## Test plan
- `CLK_DIV`=16, send 0xA5 (8N1, 16 cycles/bit):
  - `RX_status` high for 1 cycle at t0+8+144+1;
  - `RX_data`=0xA5;
  - `RX_err` stays 0.
- Low glitch of 4 cycles on an idle line:
  - `RX_busy` pulses;
  - FSM returns to IDLE at the t0+8 check;
  - no `RX_status`, no `RX_err`; `RX_data` unchanged.
- Frame 0x3C with stop bit driven 0, line held low 3 bit times, then high, then a frame of 0x55:
  - exactly one `RX_err` pulse;
  - `RX_data` keeps its previous value through the error;
  - then `RX_status` with `RX_data`=0x55.
- Continuous stream 0x00, 0xFF, 0x81 with single stop bits: three `RX_status` pulses carrying 0x00, 0xFF, 0x81 in order.
- Reset asserted in the middle of data bit 4 of a frame:
  - all outputs go to 0 asynchronously;
  - after release and the line idling high, frame 0x7E is received correctly.
- Default `CLK_DIV`=5208, looped back from the team's UART transmitter sending 0x5A: `RX_data`=0x5A with `RX_status` about 49478 cycles after the start edge.
